// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Build option: ARB_TIMEOUT_EN compiles in the forced-release hold counter.
package arb_pkg;

   localparam int unsigned NUM_REQ          = 4;
   localparam int unsigned IDX_W            = 2;
   localparam int unsigned MAX_HOLD_DEFAULT = 15;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // One-hot grant vector for a requester index.
   function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector: first requester after ptr, wrapping, ptr itself last.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the nearest hit after ptr wins.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k + 1);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/round_robin_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and no direct handoff.
// Build option: ARB_TIMEOUT_EN bounds each grant to MAX_HOLD cycles and pulses timeout.
module round_robin_arbiter4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
   parameter int unsigned CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_id,
   output logic               busy,
   output logic               timeout
);

   // The hold counter must be able to reach MAX_HOLD-1.
   if (MAX_HOLD == 0 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
      $error("round_robin_arbiter4: need 0 < MAX_HOLD < 2**CNT_W");
   end

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
   logic               busy_q, busy_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               owner_req;
   logic               hold_expired;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_req = req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));

   // Hold counter restarts on every grant entry and counts GRANT cycles.
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) cnt_d = '0;
         end
         GRANT: begin
            if (owner_req && hold_expired) timeout_d = 1'b1;
            else if (owner_req)            cnt_d     = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = GRANT;
         GRANT:   if (!owner_req || hold_expired) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and the round-robin pointer.
   always_comb begin
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d    = idx2onehot(pick_idx);
               gnt_id_d = pick_idx;
               busy_d   = 1'b1;
               ptr_d    = pick_idx;
            end
         end
         GRANT: begin
            if (!owner_req || hold_expired) begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end
         end
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   // Pointer resets to 3 so requester 0 has first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= IDX_W'(NUM_REQ - 1);
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// Bench for round_robin_arbiter4: per-cycle model comparison plus directed literal checks.
module tb_round_robin_arbiter4;

   localparam int unsigned MAX_HOLD = 15;
   localparam int unsigned CNT_W    = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: who owns the resource, who owned it last, how long it has held.
   int m_owner = -1;
   int m_last  = 3;
   int m_id    = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   round_robin_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [3:0] r);
      bit hit;
      int c;
      m_to = 1'b0;
      if (m_owner < 0) begin
         hit = 1'b0;
         for (int off = 1; off <= 4; off++) begin
            c = (m_last + off) % 4;
            if (!hit && r[c]) begin
               hit     = 1'b1;
               m_owner = c;
               m_last  = c;
               m_id    = c;
               m_held  = 1;
            end
         end
      end else if (!r[m_owner]) begin
         m_owner = -1;
      end else if (TO_EN && m_held >= int'(MAX_HOLD)) begin
         m_owner = -1;
         m_to    = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin
      logic [3:0] exp_gnt;
      if (rst) begin
         m_owner = -1; m_last = 3; m_id = 0; m_held = 0; m_to = 1'b0;
      end else begin
         model_step(req);
      end
      exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      #1;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("gnt_id", 32'(gnt_id), 32'(m_id));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("timeout", 32'(timeout), 32'(m_to));
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
   end

   initial begin
      logic [3:0] rot [4];
      int held_cnt;
      bit saw_to;
      rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_gnt_id", 32'(gnt_id), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);

      // All requesting: grants rotate with one idle cycle between owners.
      rst = 1'b0;
      req = 4'b1111;
      @(negedge clk);
      check("first_gnt", 32'(gnt), 32'h1);
      for (int i = 0; i < 4; i++) begin
         req = 4'b1111 & ~gnt;
         @(negedge clk);
         check("rot_idle", 32'(gnt), 32'h0);
         req = 4'b1111;
         @(negedge clk);
         check("rot_gnt", 32'(gnt), 32'(rot[i]));
      end

      // No preemption; release hands over after one idle cycle.
      req = 4'b0000;
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk);
      check("hold_gnt", 32'(gnt), 32'h4);
      req = 4'b1101;
      @(negedge clk);
      check("nopreempt_gnt", 32'(gnt), 32'h4);
      req = 4'b1001;
      @(negedge clk);
      check("drop_idle", 32'(gnt), 32'h0);
      @(negedge clk);
      check("next_gnt", 32'(gnt), 32'h8);
      check("next_id", 32'(gnt_id), 32'h3);

      // Lone pulsing requester is regranted every second cycle.
      req = 4'b0000;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         req = 4'b0010;
         @(negedge clk);
         check("pulse_gnt", 32'(gnt), 32'h2);
         check("pulse_busy", 32'(busy), 32'h1);
         req = 4'b0000;
         @(negedge clk);
         check("pulse_idle", 32'(gnt), 32'h0);
         check("pulse_busy0", 32'(busy), 32'h0);
         check("pulse_id", 32'(gnt_id), 32'h1);
      end

      // Asynchronous reset mid-grant.
      req = 4'b0010;
      @(negedge clk);
      check("pre_rst_gnt", 32'(gnt), 32'h2);
      #2 rst = 1'b1;
      #1;
      check("async_gnt", 32'(gnt), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_to", 32'(timeout), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0100;
      @(negedge clk);
      check("post_rst_gnt", 32'(gnt), 32'h4);
      check("post_rst_id", 32'(gnt_id), 32'h2);

      // Long hold by requester 2 with requester 0 waiting.
      req = 4'b0000;
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk);
      req = 4'b0101;
      held_cnt = 0;
      saw_to = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (gnt != 4'b0100) break;
         held_cnt++;
         if (timeout) saw_to = 1'b1;
         @(negedge clk);
      end
      if (TO_EN) begin
         check("hold_len", 32'(held_cnt), 32'd15);
         check("to_pulse", 32'(timeout), 32'h1);
         check("to_idle", 32'(gnt), 32'h0);
         @(negedge clk);
         check("to_next_gnt", 32'(gnt), 32'h1);
         check("to_clear", 32'(timeout), 32'h0);
      end else begin
         check("hold_len", 32'(held_cnt), 32'd120);
         check("no_to", 32'(saw_to), 32'h0);
      end

      req = 4'b0000;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter4.md
ROUND_ROBIN_ARBITER4 -- requirements
Module: round_robin_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 15, is the maximum grant length in cycles when the timeout is compiled in.
REQ-002 Parameter CNT_W, default 4, is the hold-counter width and SHALL satisfy 2**CNT_W > MAX_HOLD.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request vector; requester i holds req[i] high for as long as it uses the shared resource.
REQ-006 gnt  output 4  registered one-hot grant vector (all-zero when idle).
REQ-007 gnt_id  output 2  registered index of the current owner; the last owner is held while idle.
REQ-008 busy  output 1  registered; high while any gnt bit is high.
REQ-009 timeout  output 1  registered single-cycle pulse on forced release; tied 0 when the timeout is compiled out.

Function
REQ-010 The state machine SHALL have two states, IDLE and GRANT; it is in GRANT exactly when busy=1.
REQ-011 2-bit round-robin pointer ptr = last granted index; search order is ptr+1, ptr+2, ptr+3, ptr, with mod-4 wrap-around (3+1 -> 0).
REQ-012 IDLE with req!=0 at edge n: gnt, gnt_id and busy reflect the selected requester after edge n, i.e. 1-cycle latency; ptr <= selected index; -> GRANT.
REQ-013 IDLE with req==0: all outputs hold; ptr holds.
REQ-014 GRANT with req[gnt_id]=1: the grant holds; the other req bits are ignored and new requests are not preempted.
REQ-015 GRANT with req[gnt_id]=0 at an edge: gnt<=0, busy<=0, -> IDLE; there is no direct handoff, so at least one all-zero gnt cycle separates two grants.
REQ-016 A requester that re-asserts req immediately after release SHALL lose to any other pending requester (fairness via ptr).
REQ-017 A single lone requester SHALL be regranted every second cycle while it keeps pulsing req.
REQ-018 gnt SHALL never have more than one bit set in any cycle.
REQ-019 Request bits that change while IDLE are sampled only at the edge; there is no combinational req->gnt path.

Reset
REQ-020 While rst=1: gnt=0, gnt_id=0, busy=0, timeout=0, state=IDLE, ptr=3 (requester 0 has first priority), hold counter=0, asynchronously.
REQ-021 rst asserted mid-grant SHALL drop gnt immediately (asynchronously) without a timeout pulse.
REQ-022 The first grant after rst deassertion follows REQ-012 on the first rising edge with rst=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: a CNT_W-bit hold counter clears on grant entry and increments each GRANT cycle.
REQ-024 When that counter reaches MAX_HOLD-1 while the owner's req is still high, the next edge SHALL force gnt<=0, busy<=0, -> IDLE, and pulse timeout=1 for one cycle.
REQ-025 With the timeout compiled in, a timed-out owner still holding req competes normally and ranks last (REQ-016).
REQ-026 Macro ARB_TIMEOUT_EN undefined: no counter logic; timeout=0 always; grants are unbounded.

Structure
REQ-027 Shared package arb_pkg SHALL hold the state enum (IDLE, GRANT), NUM_REQ=4, and the default MAX_HOLD.
REQ-028 Sub-module rr_pick4 SHALL be combinational: inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0] per REQ-011; no state.

Verification
REQ-029 Reset, then req=4'b1111 held -> gnt=0001 one cycle after the first edge; after each release of the owner's req bit, grants rotate 0010, 0100, 1000, 0001 with one idle cycle between grants.
REQ-030 With gnt=0100, raise req[0] and req[3] -> gnt stays 0100; drop req[2] -> gnt=0000 for one cycle, then gnt=1000 with gnt_id=3.
REQ-031 Only req[1] pulsing (high until granted, low one cycle, repeat) -> gnt alternates 0010/0000; ptr stays 1; busy toggles.
REQ-032 rst asserted while gnt=0010 -> gnt=0000 and busy=0 without waiting for a clock edge; the next req=0100 after release is granted as 0100.
REQ-033 ARB_TIMEOUT_EN with MAX_HOLD=15, req[2] held forever and req[0] high -> gnt=0100 for exactly 15 cycles, then timeout=1 for one cycle; gnt=0001 next.
REQ-034 Without ARB_TIMEOUT_EN, same stimulus as REQ-033 -> gnt=0100 held for 100+ cycles, timeout=0 throughout.
